// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and checker result bundle; master drives lamps/clear, slave is the monitor.
// Pure wiring, no latency; the lamp side has no backpressure.
interface traffic_light_monitor_if #(
    parameter int CNT_W     = 16,
    parameter int ERR_CNT_W = 8
);
    logic                 red_i;
    logic                 yellow_i;
    logic                 green_i;
    logic                 clear_i;
    logic [1:0]           phase_o;
    logic [CNT_W-1:0]     dwell_o;
    logic                 err_onehot_o;
    logic                 err_seq_o;
    logic                 err_dwell_o;
    logic                 err_sticky_o;
    logic [ERR_CNT_W-1:0] err_count_o;
    logic [CNT_W-1:0]     rounds_o;

    modport master (
        output red_i, yellow_i, green_i, clear_i,
        input  phase_o, dwell_o, err_onehot_o, err_seq_o, err_dwell_o,
        input  err_sticky_o, err_count_o, rounds_o
    );

    modport slave (
        input  red_i, yellow_i, green_i, clear_i,
        output phase_o, dwell_o, err_onehot_o, err_seq_o, err_dwell_o,
        output err_sticky_o, err_count_o, rounds_o
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive one-hot / sequence / dwell checker for traffic lamps; all outputs registered, 1 cycle after sampling.
// Observes only: never stalls or alters the lamps, samples every edge.
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 11,
    parameter int GREEN_CYCLES  = 21,
    parameter int YELLOW_CYCLES = 3,
    parameter int CNT_W         = 16,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    traffic_light_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0]     DWELL_MAX  = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;
    localparam logic [CNT_W-1:0]     RED_EXP    = CNT_W'(RED_CYCLES);
    localparam logic [CNT_W-1:0]     GREEN_EXP  = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0]     YELLOW_EXP = CNT_W'(YELLOW_CYCLES);

    phase_e               phase_q;
    logic [CNT_W-1:0]     dwell_q;
    logic                 first_q;
    logic                 err_onehot_q;
    logic                 err_seq_q;
    logic                 err_dwell_q;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0]     rounds_q;

    logic             lamp_vld;
    phase_e           lamp_ph;
    phase_e           succ_ph;
    logic [CNT_W-1:0] exp_cyc;
    logic             same_ph;
    logic             trans;
    logic             e_onehot;
    logic             e_seq;
    logic             e_dwell;
    logic             any_err;
    logic             legal_round;

    always_comb begin
        lamp_vld    = $onehot({mon.red_i, mon.green_i, mon.yellow_i});
        lamp_ph     = PH_SYNC;
        succ_ph     = PH_SYNC;
        exp_cyc     = '0;
        if (mon.red_i)         lamp_ph = PH_RED;
        else if (mon.green_i)  lamp_ph = PH_GREEN;
        else if (mon.yellow_i) lamp_ph = PH_YELLOW;

        case (phase_q)
            PH_RED:    begin exp_cyc = RED_EXP;    succ_ph = PH_GREEN;  end
            PH_GREEN:  begin exp_cyc = GREEN_EXP;  succ_ph = PH_YELLOW; end
            PH_YELLOW: begin exp_cyc = YELLOW_EXP; succ_ph = PH_RED;    end
            default:   begin exp_cyc = '0;         succ_ph = PH_SYNC;   end
        endcase

        same_ph  = (phase_q != PH_SYNC) && lamp_vld && (lamp_ph == phase_q);
        trans    = (phase_q != PH_SYNC) && lamp_vld && (lamp_ph != phase_q);
        e_onehot = !lamp_vld;
        // Overrun fires only on the EXP -> EXP+1 step; the first phase after sync may be partial.
        e_dwell  = !first_q && ((same_ph && (dwell_q == exp_cyc)) ||
                                (trans && (dwell_q < exp_cyc)));
        e_seq       = trans && (lamp_ph != succ_ph);
        legal_round = trans && (phase_q == PH_YELLOW) && (lamp_ph == PH_RED);
        any_err     = e_onehot || e_seq || e_dwell;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q      <= PH_SYNC;
            dwell_q      <= '0;
            first_q      <= 1'b1;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_dwell_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            rounds_q     <= '0;
        end else begin
            if (!lamp_vld) begin
                phase_q <= PH_SYNC;
                dwell_q <= '0;
                first_q <= 1'b1;
            end else if ((phase_q == PH_SYNC) || trans) begin
                phase_q <= lamp_ph;
                dwell_q <= CNT_W'(1);
                first_q <= (phase_q == PH_SYNC);
            end else if (dwell_q != DWELL_MAX) begin
                dwell_q <= dwell_q + 1'b1;
            end

            err_onehot_q <= e_onehot;
            err_seq_q    <= e_seq;
            err_dwell_q  <= e_dwell;
            // An error on the clearing edge takes precedence over the clear.
            err_sticky_q <= any_err || (err_sticky_q && !mon.clear_i);
            if (mon.clear_i)
                err_count_q <= any_err ? ERR_CNT_W'(1) : '0;
            else if (any_err && (err_count_q != ERR_MAX))
                err_count_q <= err_count_q + 1'b1;

            if (legal_round)
                rounds_q <= rounds_q + 1'b1;
        end
    end

    assign mon.phase_o      = phase_q;
    assign mon.dwell_o      = dwell_q;
    assign mon.err_onehot_o = err_onehot_q;
    assign mon.err_seq_o    = err_seq_q;
    assign mon.err_dwell_o  = err_dwell_q;
    assign mon.err_sticky_o = err_sticky_q;
    assign mon.err_count_o  = err_count_q;
    assign mon.rounds_o     = rounds_q;
endmodule
